// File: rtl/mult_seq_if.sv
// mult_seq_if -- request/result bundle for the sequential multiplier.
//   start      : begin a multiplication (sampled on rising clk)
//   a, b       : N-bit unsigned operands, captured when start is accepted
//   y          : 2N-bit product register
//   busy       : high while a multiplication is in progress
//   done       : one-cycle pulse when y holds a new product
// master drives the request side; slave is the multiplier.
interface mult_seq_if #(
    parameter int N = 8
);
    logic             start;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic [2*N-1:0]   y;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b,
        input  y, busy, done
    );

    modport slave (
        input  start, a, b,
        output y, busy, done
    );
endinterface

// File: rtl/mult_seq.sv
// mult_seq -- shift-and-add unsigned multiplier, fixed N-cycle latency.
//   clk    : single clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mult_seq_if slave (start, a, b in; y, busy, done out)
// Flow: IDLE accepts start and captures operands; BUSY runs exactly N
// add/shift steps; DONE holds done high for one cycle, then back to IDLE.
module mult_seq #(
    parameter int N = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    mult_seq_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [2*N-1:0]   mcand;
    logic [2*N-1:0]   acc;
    logic [2*N-1:0]   acc_next;
    logic [N-1:0]     mplier;
    logic [CW-1:0]    cnt;
    logic [2*N-1:0]   y_r;

    // One partial-product step; also the value committed to y on the last step,
    // so y never exposes a partial sum.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            y_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand  <= {{N{1'b0}}, bus.a};
                        mplier <= bus.b;
                        acc    <= '0;
                        cnt    <= CW'(N);
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    // Counter reaches 0 on this edge: final step.
                    if (cnt == CW'(1)) begin
                        y_r   <= acc_next;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.y    = y_r;
    assign bus.busy = (state == BUSY) || (state == DONE);
    assign bus.done = (state == DONE);
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq -- directed self-checking bench for mult_seq (N=8).
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_mult_seq;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mult_seq_if #(.N(8)) bus ();

    mult_seq #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle, scramble operands afterwards, then check
    // cycles 1..10 after the accepting edge.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input logic [15:0] exp, input logic [15:0] prev,
                          input string tag);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~av;
        bus.b     = ~bv;
        for (int i = 1; i <= 10; i++) begin
            if (i > 1) @(negedge clk);
            chk({tag, "_busy"}, 16'(bus.busy), 16'(i <= 9));
            chk({tag, "_done"}, 16'(bus.done), 16'(i == 9));
            chk({tag, "_y"},    bus.y,         (i >= 9) ? exp : prev);
        end
    endtask

    initial begin
        int ndone;
        logic prev_done;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state
        #12;
        chk("rst_y",    bus.y,             16'd0);
        chk("rst_busy", 16'(bus.busy),     16'd0);
        chk("rst_done", 16'(bus.done),     16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic products and zero-operand fixed latency
        run_op(8'd13,  8'd11,  16'd143,   16'd0,     "p13x11");
        run_op(8'd255, 8'd255, 16'hFE01,  16'd143,   "p255x255");
        run_op(8'd0,   8'd200, 16'd0,     16'hFE01,  "p0x200");
        run_op(8'd200, 8'd0,   16'd0,     16'd0,     "p200x0");
        run_op(8'd7,   8'd6,   16'd42,    16'd0,     "p7x6a");

        // start and operand changes during BUSY are ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd7;
        bus.b     = 8'd6;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 8'd100;
        bus.b     = 8'd100;
        ndone = 0;
        for (int i = 1; i <= 14; i++) begin
            if (i > 1) @(negedge clk);
            if (bus.done) ndone++;
            chk("ign_busy", 16'(bus.busy), 16'(i <= 9));
            chk("ign_done", 16'(bus.done), 16'(i == 9));
            if (i >= 9) chk("ign_y", bus.y, 16'd42);
            bus.start = (i == 3 || i == 8);
        end
        chk("ign_ndone", 16'(ndone), 16'd1);

        // start held high: back-to-back products every N+2 cycles
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd3;
        bus.b     = 8'd5;
        prev_done = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            chk("hold_done", 16'(bus.done), 16'((c % 10) == 9));
            chk("hold_busy", 16'(bus.busy), 16'((c % 10) != 0));
            chk("hold_y",    bus.y,         (c >= 9) ? 16'd15 : 16'd42);
            chk("hold_nodbl", 16'(bus.done && prev_done), 16'd0);
            prev_done = bus.done;
            if (c == 29) bus.start = 1'b0;
        end

        // Asynchronous reset on the 4th BUSY cycle aborts the operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd9;
        bus.b     = 8'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_pre_busy", 16'(bus.busy), 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_y",    bus.y,         16'd0);
        chk("abort_busy", 16'(bus.busy), 16'd0);
        chk("abort_done", 16'(bus.done), 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            chk("post_done", 16'(bus.done), 16'd0);
            chk("post_busy", 16'(bus.busy), 16'd0);
            chk("post_y",    bus.y,         16'd0);
        end
        run_op(8'd2, 8'd3, 16'd6, 16'd0, "p2x3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
